// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: drives an SRAM-like instruction bus and
// delivers fetched words to the IF/ID register with one request in flight.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        pred_take,
    input  logic [31:0] pred_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_inst_req,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_addr_error
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] if_pc_q;
    logic [31:0] buffer;
    logic        cancel;
    logic        misaligned;

    assign misaligned = pc[1:0] != 2'b00;
    assign inst_addr  = pc;

    always_comb begin
        inst_req      = 1'b0;
        if_inst_req   = 1'b0;
        if_addr_error = 1'b0;
        if_inst       = 32'h0;
        if_pc         = if_pc_q;
        if (!reset) begin
            case (state)
                S_REQ: begin
                    // a misaligned pc is reported as a faulting slot, never fetched
                    if (misaligned) begin
                        if_pc = pc;
                        if (!redirect) begin
                            if_inst_req   = 1'b1;
                            if_addr_error = 1'b1;
                        end
                    end else begin
                        inst_req = !redirect;
                    end
                end
                S_WAIT: begin
                    if_inst     = inst_rdata;
                    if_inst_req = inst_data_ok && !cancel && !redirect;
                end
                S_HOLD: begin
                    if_inst     = buffer;
                    if_inst_req = !redirect;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_REQ;
            pc      <= RESET_PC;
            cancel  <= 1'b0;
            buffer  <= 32'h0;
            if_pc_q <= 32'h0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                    end else if (misaligned) begin
                        if (!stall) pc <= pc + 32'd4;
                    end else if (inst_addr_ok) begin
                        state   <= S_WAIT;
                        if_pc_q <= pc;
                        pc      <= pred_take ? pred_target : pc + 32'd4;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        if (cancel || redirect) begin
                            cancel <= 1'b0;
                            state  <= S_REQ;
                            if (redirect) pc <= redirect_pc;
                        end else if (stall) begin
                            state  <= S_HOLD;
                            buffer <= inst_rdata;
                        end else begin
                            state <= S_REQ;
                        end
                    end else if (redirect) begin
                        // the in-flight response belongs to the old path
                        cancel <= 1'b1;
                        pc     <= redirect_pc;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        state <= S_REQ;
                        pc    <= redirect_pc;
                    end else if (!stall) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule
